gem_score_tracker: RTL and testbench



---
 rtl/gem_score_tracker.sv | 173 +++++++++++++++++
 tb/tb_gem_score_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_score_tracker.sv
// Typed gem collection with blink-out, saturating BCD score drain, and gem/score pixel overlays.
// Score and collect_pulse are registered; the draw outputs are combinational from DrawX/DrawY and state.
module gem_score_tracker #(
   parameter int GEM_COUNT    = 8,
   parameter int GEM_W        = 24,
   parameter int GEM_H        = 19,
   parameter int SCORE_DIGITS = 2,
   parameter int SCORE_X      = 300,
   parameter int SCORE_Y      = 40,
   parameter int BLINK_FRAMES = 12
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      level_restart,
   input  logic                      frame_tick,
   input  logic [9:0]                DrawX,
   input  logic [9:0]                DrawY,
   input  logic [10*GEM_COUNT-1:0]   gem_x,
   input  logic [10*GEM_COUNT-1:0]   gem_y,
   input  logic [GEM_COUNT-1:0]      gem_is_ice,
   input  logic signed [15:0]        player1_top,
   input  logic signed [15:0]        player1_bottom,
   input  logic signed [15:0]        player1_left,
   input  logic signed [15:0]        player1_right,
   input  logic signed [15:0]        player2_top,
   input  logic signed [15:0]        player2_bottom,
   input  logic signed [15:0]        player2_left,
   input  logic signed [15:0]        player2_right,
   input  logic [7:0]                font_data,
   output logic                      is_gem,
   output logic [8:0]                gem_rom_addr,
   output logic                      gem_pix_ice,
   output logic                      is_score,
   output logic [10:0]               font_addr,
   output logic                      score_pixel,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic                      collect_pulse,
   output logic                      all_collected
);
   localparam logic [1:0] ACTIVE = 2'd0;
   localparam logic [1:0] BLINK  = 2'd1;
   localparam logic [1:0] GONE   = 2'd2;
   localparam logic signed [15:0] GW = 16'(GEM_W);
   localparam logic signed [15:0] GH = 16'(GEM_H);

   logic [1:0]               state     [GEM_COUNT];
   logic [1:0]               state_nxt [GEM_COUNT];
   logic [3:0]               blink_cnt [GEM_COUNT];
   logic [3:0]               blink_nxt [GEM_COUNT];
   logic [GEM_COUNT-1:0]     pending;
   logic [GEM_COUNT-1:0]     pend_set;
   logic [GEM_COUNT-1:0]     drain_bit;
   logic [GEM_COUNT-1:0]     visible;
   logic [4*SCORE_DIGITS-1:0] score_inc;
   logic                     carry;
   logic                     all_nines;
   logic                     all_left;
   logic [10:0]              offx, offy, sx, sy;
   logic [3:0]               digit;

   function automatic logic overlaps(input logic signed [15:0] l, input logic signed [15:0] r,
                                     input logic signed [15:0] t, input logic signed [15:0] b,
                                     input logic [9:0] gx, input logic [9:0] gy);
      logic signed [15:0] x0, y0;
      x0 = $signed({6'b0, gx});
      y0 = $signed({6'b0, gy});
      return (r > x0) && (l < x0 + GW) && (b > y0) && (t < y0 + GH);
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset || level_restart) begin
         for (int i = 0; i < GEM_COUNT; i++) begin
            state[i]     <= ACTIVE;
            blink_cnt[i] <= 4'd0;
         end
         pending       <= '0;
         score_bcd     <= '0;
         collect_pulse <= 1'b0;
         all_collected <= 1'b0;
      end else begin
         for (int i = 0; i < GEM_COUNT; i++) begin
            state[i]     <= state_nxt[i];
            blink_cnt[i] <= blink_nxt[i];
         end
         // A freshly set bit never collides with the drained one: each gem enters BLINK once.
         pending       <= (pending & ~drain_bit) | pend_set;
         collect_pulse <= |pending;
         if (|pending && !all_nines)
            score_bcd <= score_inc;
         all_collected <= all_left;
      end
   end

   always_comb begin
      for (int i = 0; i < GEM_COUNT; i++) begin
         state_nxt[i] = state[i];
         blink_nxt[i] = blink_cnt[i];
         pend_set[i]  = 1'b0;
         case (state[i])
            ACTIVE: begin
               if (gem_is_ice[i] ? overlaps(player2_left, player2_right, player2_top, player2_bottom,
                                            gem_x[10*i +: 10], gem_y[10*i +: 10])
                                 : overlaps(player1_left, player1_right, player1_top, player1_bottom,
                                            gem_x[10*i +: 10], gem_y[10*i +: 10])) begin
                  state_nxt[i] = BLINK;
                  blink_nxt[i] = 4'(BLINK_FRAMES);
                  pend_set[i]  = 1'b1;
               end
            end
            BLINK: begin
               if (frame_tick) begin
                  blink_nxt[i] = blink_cnt[i] - 4'd1;
                  if (blink_cnt[i] == 4'd1)
                     state_nxt[i] = GONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      drain_bit = pending & (~pending + GEM_COUNT'(1));
      all_left  = 1'b1;
      for (int i = 0; i < GEM_COUNT; i++)
         if (state[i] == ACTIVE)
            all_left = 1'b0;
      score_inc = score_bcd;
      carry     = 1'b1;
      all_nines = 1'b1;
      for (int d = 0; d < SCORE_DIGITS; d++) begin
         if (score_bcd[4*d +: 4] != 4'd9)
            all_nines = 1'b0;
         if (carry) begin
            if (score_bcd[4*d +: 4] == 4'd9) begin
               score_inc[4*d +: 4] = 4'd0;
            end else begin
               score_inc[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   always_comb begin
      is_gem       = 1'b0;
      gem_rom_addr = 9'd0;
      gem_pix_ice  = 1'b0;
      offx         = 11'd0;
      offy         = 11'd0;
      // Scan high to low so the lowest-index hit is the one left standing.
      for (int i = GEM_COUNT - 1; i >= 0; i--) begin
         visible[i] = (state[i] == ACTIVE) || ((state[i] == BLINK) && !blink_cnt[i][1]);
         offx = {1'b0, DrawX} - {1'b0, gem_x[10*i +: 10]};
         offy = {1'b0, DrawY} - {1'b0, gem_y[10*i +: 10]};
         if (visible[i] && !offx[10] && (offx < 11'(GEM_W)) && !offy[10] && (offy < 11'(GEM_H))) begin
            is_gem       = 1'b1;
            gem_rom_addr = 9'(offx) + 9'(offy) * 9'(GEM_W);
            gem_pix_ice  = gem_is_ice[i];
         end
      end

      sx       = {1'b0, DrawX} - 11'(SCORE_X);
      sy       = {1'b0, DrawY} - 11'(SCORE_Y);
      is_score = !sx[10] && (sx < 11'(SCORE_DIGITS * 8)) && !sy[10] && (sy < 11'd16);
      digit    = 4'd0;
      for (int d = 0; d < SCORE_DIGITS; d++)
         if (sx[4:3] == 2'(d))
            digit = score_bcd[4*(SCORE_DIGITS-1-d) +: 4];
      font_addr   = is_score ? {7'h30 + {3'b000, digit}, sy[3:0]} : 11'd0;
      score_pixel = is_score & font_data[3'd7 - sx[2:0]];
   end
endmodule

// File: tb/tb_gem_score_tracker.sv
// Bench for gem_score_tracker: directed scenarios plus random play against a behavioural model.
module tb_gem_score_tracker;
   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic               Reset, level_restart, frame_tick;
   logic [9:0]         DrawX, DrawY;
   logic [159:0]       gem_x, gem_y;
   logic [15:0]        gem_is_ice;
   logic signed [15:0] p1t, p1b, p1l, p1r, p2t, p2b, p2l, p2r;
   logic [7:0]         font_data;

   logic       is_gem, gem_pix_ice, is_score, score_pixel, collect_pulse, all_collected;
   logic [8:0] gem_rom_addr;
   logic [10:0] font_addr;
   logic [7:0] score_bcd;
   logic       is_gem1, gem_pix_ice1, is_score1, score_pixel1, collect_pulse1, all_collected1;
   logic [8:0] gem_rom_addr1;
   logic [10:0] font_addr1;
   logic [3:0] score_bcd1;

   gem_score_tracker #(.GEM_COUNT(16), .SCORE_DIGITS(2)) dut (
      .Clk(Clk), .Reset(Reset), .level_restart(level_restart), .frame_tick(frame_tick),
      .DrawX(DrawX), .DrawY(DrawY), .gem_x(gem_x), .gem_y(gem_y), .gem_is_ice(gem_is_ice),
      .player1_top(p1t), .player1_bottom(p1b), .player1_left(p1l), .player1_right(p1r),
      .player2_top(p2t), .player2_bottom(p2b), .player2_left(p2l), .player2_right(p2r),
      .font_data(font_data), .is_gem(is_gem), .gem_rom_addr(gem_rom_addr), .gem_pix_ice(gem_pix_ice),
      .is_score(is_score), .font_addr(font_addr), .score_pixel(score_pixel), .score_bcd(score_bcd),
      .collect_pulse(collect_pulse), .all_collected(all_collected));

   gem_score_tracker #(.GEM_COUNT(16), .SCORE_DIGITS(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .level_restart(level_restart), .frame_tick(frame_tick),
      .DrawX(DrawX), .DrawY(DrawY), .gem_x(gem_x), .gem_y(gem_y), .gem_is_ice(gem_is_ice),
      .player1_top(p1t), .player1_bottom(p1b), .player1_left(p1l), .player1_right(p1r),
      .player2_top(p2t), .player2_bottom(p2b), .player2_left(p2l), .player2_right(p2r),
      .font_data(font_data), .is_gem(is_gem1), .gem_rom_addr(gem_rom_addr1), .gem_pix_ice(gem_pix_ice1),
      .is_score(is_score1), .font_addr(font_addr1), .score_pixel(score_pixel1), .score_bcd(score_bcd1),
      .collect_pulse(collect_pulse1), .all_collected(all_collected1));

   int checks = 0, errors = 0;
   // Model: blk = -1 active, >0 frames of blink left, 0 gone; count = total collections drained.
   int blk [16];
   bit pend [16];
   int count;
   bit m_pulse, m_allc;
   int gxa [16], gya [16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (x=%0d y=%0d t=%0t)", name, act, exp, DrawX, DrawY, $time);
      end
   endtask

   function automatic bit ov(input int who, input int i);
      int l, r, t, b;
      if (who == 1) begin l = p1l; r = p1r; t = p1t; b = p1b; end
      else          begin l = p2l; r = p2r; t = p2t; b = p2b; end
      return (r > gxa[i]) && (l < gxa[i] + 24) && (b > gya[i]) && (t < gya[i] + 19);
   endfunction

   task automatic check();
      int s1, s2, dx, dy, ox, oy, eg, ea, ei;
      bit vis, in1, in2;
      eg = 0; ea = 0; ei = 0;
      for (int i = 0; i < 16; i++) begin
         vis = (blk[i] == -1) || (blk[i] > 0 && ((blk[i] >> 1) & 1) == 0);
         dx = int'(DrawX) - gxa[i];
         dy = int'(DrawY) - gya[i];
         if (eg == 0 && vis && dx >= 0 && dx < 24 && dy >= 0 && dy < 19) begin
            eg = 1; ea = dx + dy * 24; ei = int'(gem_is_ice[i]);
         end
      end
      s2 = (count > 99) ? 99 : count;
      s1 = (count > 9) ? 9 : count;
      chk("score", int'(score_bcd), (s2 / 10) * 16 + s2 % 10);
      chk("score_1digit", int'(score_bcd1), s1);
      chk("collect_pulse", int'(collect_pulse), int'(m_pulse));
      chk("collect_pulse_1digit", int'(collect_pulse1), int'(m_pulse));
      chk("all_collected", int'(all_collected), int'(m_allc));
      chk("all_collected_1digit", int'(all_collected1), int'(m_allc));
      chk("is_gem", int'(is_gem), eg);
      chk("gem_rom_addr", int'(gem_rom_addr), ea);
      chk("gem_pix_ice", int'(gem_pix_ice), ei);
      chk("is_gem_1digit", int'(is_gem1), eg);
      ox = int'(DrawX) - 300;
      oy = int'(DrawY) - 40;
      in2 = ox >= 0 && ox < 16 && oy >= 0 && oy < 16;
      in1 = ox >= 0 && ox < 8 && oy >= 0 && oy < 16;
      chk("is_score", int'(is_score), int'(in2));
      chk("is_score_1digit", int'(is_score1), int'(in1));
      chk("score_pixel", int'(score_pixel), in2 ? int'(font_data[7 - ox % 8]) : 0);
      if (in2) chk("font_addr", int'(font_addr), (48 + ((ox < 8) ? s2 / 10 : s2 % 10)) * 16 + oy);
      if (in1) chk("font_addr_1digit", int'(font_addr1), (48 + s1) * 16 + oy);
   endtask

   task automatic step();
      int nb [16];
      bit np [16];
      int low, ncount;
      bit npulse, nallc;
      if (Reset || level_restart) begin
         for (int i = 0; i < 16; i++) begin nb[i] = -1; np[i] = 0; end
         ncount = 0; npulse = 0; nallc = 0;
      end else begin
         low = -1;
         for (int i = 0; i < 16; i++) begin
            np[i] = pend[i];
            if (pend[i] && low < 0) low = i;
         end
         ncount = count;
         npulse = (low >= 0);
         if (low >= 0) begin np[low] = 0; ncount++; end
         nallc = 1;
         for (int i = 0; i < 16; i++) if (blk[i] == -1) nallc = 0;
         for (int i = 0; i < 16; i++) begin
            nb[i] = blk[i];
            if (blk[i] == -1) begin
               if (gem_is_ice[i] ? ov(2, i) : ov(1, i)) begin nb[i] = 12; np[i] = 1; end
            end else if (blk[i] > 0 && frame_tick) begin
               nb[i] = blk[i] - 1;
            end
         end
      end
      @(posedge Clk);
      for (int i = 0; i < 16; i++) begin blk[i] = nb[i]; pend[i] = np[i]; end
      count = ncount; m_pulse = npulse; m_allc = nallc;
      @(negedge Clk);
      check();
   endtask

   task automatic set_box(input int who, input int l, input int r, input int t, input int b);
      if (who == 1) begin p1l = 16'(l); p1r = 16'(r); p1t = 16'(t); p1b = 16'(b); end
      else          begin p2l = 16'(l); p2r = 16'(r); p2t = 16'(t); p2b = 16'(b); end
   endtask

   task automatic park();
      set_box(1, -100, -90, -100, -90);
      set_box(2, -100, -90, -100, -90);
   endtask

   task automatic place(input int who, input int j);
      set_box(who, gxa[j] + 2, gxa[j] + 10, gya[j] + 2, gya[j] + 10);
   endtask

   initial begin
      int j, l, t;
      for (int i = 0; i < 16; i++) begin
         gxa[i] = (i == 0) ? 320 : (i == 1) ? 360 : 10 + 40 * (i - 2);
         gya[i] = (i < 2) ? 440 : 100;
         gem_x[10*i +: 10] = 10'(gxa[i]);
         gem_y[10*i +: 10] = 10'(gya[i]);
         gem_is_ice[i] = (i % 2 == 1);
         blk[i] = -1; pend[i] = 0;
      end
      count = 0; m_pulse = 0; m_allc = 0;
      Reset = 1; level_restart = 0; frame_tick = 0; font_data = 8'h00;
      DrawX = 10'd325; DrawY = 10'd445;
      park();
      @(negedge Clk);
      step(); step();
      Reset = 0;
      chk("lit_reset_score", int'(score_bcd), 0);
      chk("lit_reset_pulse", int'(collect_pulse), 0);
      chk("lit_reset_allc", int'(all_collected), 0);
      chk("lit_gem0_visible", int'(is_gem), 1);
      chk("lit_gem0_addr", int'(gem_rom_addr), 125);

      // Touching edge only: strict overlap means no collection.
      set_box(1, 300, 320, 442, 450); step(); park(); step();
      chk("lit_touch_no_collect", int'(score_bcd), 0);
      place(1, 0); step(); park();
      chk("lit_blink_no_pulse_yet", int'(collect_pulse), 0);
      step();
      chk("lit_first_pulse", int'(collect_pulse), 1);
      chk("lit_score_01", int'(score_bcd), 8'h01);
      place(1, 1); step(); park(); step(); step();
      chk("lit_wrong_type_ignored", int'(score_bcd), 8'h01);

      place(1, 2); place(2, 3); step(); park();
      step();
      chk("lit_dual_score_02", int'(score_bcd), 8'h02);
      step();
      chk("lit_dual_score_03", int'(score_bcd), 8'h03);
      chk("lit_dual_second_pulse", int'(collect_pulse), 1);
      step();

      for (int k = 0; k < 12; k++) begin
         frame_tick = 1; step(); frame_tick = 0;
         if (k == 0) chk("lit_blink_cnt11_hidden", int'(is_gem), 0);
         if (k == 2) chk("lit_blink_cnt9_visible", int'(is_gem), 1);
         step();
      end
      chk("lit_gone_hidden", int'(is_gem), 0);

      set_box(1, 95, 175, 102, 110); set_box(2, 95, 175, 102, 110);
      step(); park();
      level_restart = 1; step(); level_restart = 0;
      chk("lit_restart_score", int'(score_bcd), 0);
      step(); step();
      chk("lit_restart_no_pulse", int'(collect_pulse), 0);
      chk("lit_restart_gem0_visible", int'(is_gem), 1);

      for (int g = 0; g < 16; g++) begin
         place(gem_is_ice[g] ? 2 : 1, g); step(); park();
      end
      step(); step(); step();
      chk("lit_score_16", int'(score_bcd), 8'h16);
      chk("lit_sat_score_9", int'(score_bcd1), 9);
      chk("lit_all_collected", int'(all_collected), 1);
      for (int y = 38; y < 58; y++)
         for (int x = 296; x < 320; x++) begin
            DrawX = 10'(x); DrawY = 10'(y); font_data = 8'($urandom);
            step();
            if (x == 300 && y == 45) chk("lit_font_tens", int'(font_addr), 'h315);
            if (x == 308 && y == 40) chk("lit_font_ones", int'(font_addr), 'h360);
         end

      level_restart = 1; step(); level_restart = 0;
      for (int c = 0; c < 3000; c++) begin
         frame_tick    = ($urandom % 4 == 0);
         level_restart = ($urandom % 100 == 0);
         Reset         = ($urandom % 300 == 0);
         font_data     = 8'($urandom);
         for (int w = 1; w <= 2; w++) begin
            if ($urandom % 2 == 0) begin
               set_box(w, -100, -90, -100, -90);
            end else begin
               j = int'($urandom_range(0, 15));
               l = gxa[j] + int'($urandom_range(0, 50)) - 30;
               t = gya[j] + int'($urandom_range(0, 40)) - 22;
               set_box(w, l, l + int'($urandom_range(1, 30)), t, t + int'($urandom_range(1, 25)));
            end
         end
         if ($urandom % 3 != 0) begin
            j = int'($urandom_range(0, 15));
            DrawX = 10'(gxa[j] + int'($urandom_range(0, 29)) - 3);
            DrawY = 10'(gya[j] + int'($urandom_range(0, 24)) - 3);
         end else begin
            DrawX = 10'($urandom_range(296, 319));
            DrawY = 10'($urandom_range(36, 59));
         end
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
